// File: rtl/gpio_pad_ctrl_pkg.sv
// Shared constants for the GPIO pad controller: register addresses and pad drive-mode codes.
// The optional debounce filter is enabled by defining GPIO_DEBOUNCE_EN.
package gpio_pad_ctrl_pkg;
    localparam logic [2:0] A_OUT    = 3'd0;
    localparam logic [2:0] A_OE     = 3'd1;
    localparam logic [2:0] A_IN     = 3'd2;
    localparam logic [2:0] A_RISE   = 3'd3;
    localparam logic [2:0] A_FALL   = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;
    localparam logic [2:0] A_DM     = 3'd6;
    localparam logic [2:0] A_DB     = 3'd7;

    localparam logic [2:0] DM_INPUT  = 3'b001;
    localparam logic [2:0] DM_STRONG = 3'b110;
endpackage

// File: rtl/gpio_in_filter.sv
// Per-pin input path: 2-flop synchronizer, optional debounce (GPIO_DEBOUNCE_EN) and edge detect.
module gpio_in_filter #(
    parameter int DBW = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           pad_i,
    input  logic [DBW-1:0] db_period_i,
    output logic           filt_o,
    output logic           rise_o,
    output logic           fall_o
);
    logic sync1_q, sync2_q, prev_q, filt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
            prev_q  <= filt;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic           stable_q, differ, settle;
    logic [DBW-1:0] cnt_q;

    // The filtered value flips combinationally on the (period+1)-th differing cycle,
    // so a zero period costs no extra latency over the bare synchronizer.
    assign differ = sync2_q != stable_q;
    assign settle = differ && (cnt_q == db_period_i);
    assign filt   = settle ? sync2_q : stable_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= filt;
            cnt_q    <= (differ && !settle) ? cnt_q + DBW'(1) : '0;
        end
    end
`else
    logic unused_db;
    assign unused_db = ^db_period_i;
    assign filt      = sync2_q;
`endif

    assign filt_o = filt;
    assign rise_o = filt & ~prev_q;
    assign fall_o = ~filt & prev_q;
endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: register file, pad drive outputs and edge-triggered level interrupt.
// Define GPIO_DEBOUNCE_EN to add the per-pin debounce filter and the DB_PERIOD register.
module gpio_pad_ctrl
    import gpio_pad_ctrl_pkg::*;
#(
    parameter int NPINS = 8,
    parameter int DBW   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [2:0]         req_addr_i,
    input  logic [31:0]        req_wdata_i,
    output logic               rsp_valid_o,
    output logic [31:0]        rsp_rdata_o,
    output logic [NPINS-1:0]   pad_out_o,
    output logic [NPINS-1:0]   pad_oe_n_o,
    output logic [3*NPINS-1:0] pad_dm_o,
    output logic [NPINS-1:0]   pad_inp_dis_o,
    input  logic [NPINS-1:0]   pad_in_i,
    output logic               irq_o
);
    logic [NPINS-1:0]   out_q, oe_q, ren_q, fen_q, status_q, status_d;
    logic [NPINS-1:0]   filt, rise, fall;
    logic [3*NPINS-1:0] dm_q;
    logic [DBW-1:0]     db_q;
    logic               rsp_valid_q, acc, wr;
    logic [31:0]        rdata_q, rdata_d;
    logic               unused_wdata;

    assign acc          = req_valid_i & ~rsp_valid_q;
    assign wr           = acc & req_we_i;
    assign unused_wdata = ^req_wdata_i;

    for (genvar i = 0; i < NPINS; i++) begin : g_pin
        gpio_in_filter #(.DBW(DBW)) u_flt (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .pad_i       (pad_in_i[i]),
            .db_period_i (db_q),
            .filt_o      (filt[i]),
            .rise_o      (rise[i]),
            .fall_o      (fall[i])
        );
    end

    always_comb begin
        rdata_d = '0;
        case (req_addr_i)
            A_OUT:    rdata_d[NPINS-1:0]   = out_q;
            A_OE:     rdata_d[NPINS-1:0]   = oe_q;
            A_IN:     rdata_d[NPINS-1:0]   = filt;
            A_RISE:   rdata_d[NPINS-1:0]   = ren_q;
            A_FALL:   rdata_d[NPINS-1:0]   = fen_q;
            A_STATUS: rdata_d[NPINS-1:0]   = status_q;
            A_DM:     rdata_d[3*NPINS-1:0] = dm_q;
            A_DB:     rdata_d[DBW-1:0]     = db_q;
            default:  rdata_d = '0;
        endcase
    end

    // New edges are OR-ed in after the W1C mask so a coincident set wins.
    always_comb begin
        status_d = status_q;
        if (wr && req_addr_i == A_STATUS)
            status_d = status_q & ~req_wdata_i[NPINS-1:0];
        status_d = status_d | (rise & ren_q) | (fall & fen_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q       <= '0;
            oe_q        <= '0;
            ren_q       <= '0;
            fen_q       <= '0;
            status_q    <= '0;
            dm_q        <= {NPINS{DM_INPUT}};
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
`ifdef GPIO_DEBOUNCE_EN
            db_q        <= '0;
`endif
        end else begin
            rsp_valid_q <= acc;
            rdata_q     <= (acc && !req_we_i) ? rdata_d : '0;
            status_q    <= status_d;
            if (wr) begin
                case (req_addr_i)
                    A_OUT:  out_q <= req_wdata_i[NPINS-1:0];
                    A_OE:   oe_q  <= req_wdata_i[NPINS-1:0];
                    A_RISE: ren_q <= req_wdata_i[NPINS-1:0];
                    A_FALL: fen_q <= req_wdata_i[NPINS-1:0];
                    A_DM:   dm_q  <= req_wdata_i[3*NPINS-1:0];
`ifdef GPIO_DEBOUNCE_EN
                    A_DB:   db_q  <= req_wdata_i[DBW-1:0];
`endif
                    default: ;
                endcase
            end
        end
    end

`ifndef GPIO_DEBOUNCE_EN
    assign db_q = '0;
`endif

    assign req_ready_o   = ~rsp_valid_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rdata_q;
    assign pad_out_o     = out_q;
    assign pad_oe_n_o    = ~oe_q;
    assign pad_dm_o      = dm_q;
    assign pad_inp_dis_o = '0;
    assign irq_o         = |status_q;
endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Randomized bench for gpio_pad_ctrl against a cycle-level behavioural model of the register map.
// Debounce checks run only when GPIO_DEBOUNCE_EN is defined.
module tb_gpio_pad_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, irq;
    logic [31:0] rsp_rdata;
    logic [7:0]  pad_out, pad_oe_n, pad_inp_dis;
    logic [7:0]  pad_in = '0;
    logic [23:0] pad_dm;

    int total = 0;
    int bad   = 0;

    // Model: register values plus history of pad samples (s0 newest).
    bit [7:0]  m_out, m_oe, m_ren, m_fen, m_st, m_db;
    bit [7:0]  s0, s1, s2;
    bit [23:0] m_dm;
    bit        m_rsp;
    bit [31:0] m_rdata;
    bit        model_on = 1'b1;

    gpio_pad_ctrl #(.NPINS(8), .DBW(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .pad_out_o(pad_out), .pad_oe_n_o(pad_oe_n), .pad_dm_o(pad_dm),
        .pad_inp_dis_o(pad_inp_dis), .pad_in_i(pad_in), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        bit        acc;
        bit [7:0]  filt_now, filt_old, set;
        bit [31:0] rd;
        @(posedge clk);
        if (rst) begin
            {m_out, m_oe, m_ren, m_fen, m_st, m_db, s0, s1, s2} = '0;
            m_dm = {8{3'b001}};
            m_rsp = 1'b0;
            m_rdata = '0;
        end else begin
            acc = req_valid && !m_rsp;
            // Filtered input lags the pad by two samples.
            filt_now = s1;
            filt_old = s2;
            set = ((filt_now & ~filt_old) & m_ren) | ((~filt_now & filt_old) & m_fen);
            rd = '0;
            if (acc && !req_we) begin
                case (req_addr)
                    3'd0: rd = {24'h0, m_out};
                    3'd1: rd = {24'h0, m_oe};
                    3'd2: rd = {24'h0, filt_now};
                    3'd3: rd = {24'h0, m_ren};
                    3'd4: rd = {24'h0, m_fen};
                    3'd5: rd = {24'h0, m_st};
                    3'd6: rd = {8'h0, m_dm};
`ifdef GPIO_DEBOUNCE_EN
                    3'd7: rd = {24'h0, m_db};
`endif
                    default: rd = '0;
                endcase
            end
            if (acc && req_we) begin
                case (req_addr)
                    3'd0: m_out = req_wdata[7:0];
                    3'd1: m_oe  = req_wdata[7:0];
                    3'd3: m_ren = req_wdata[7:0];
                    3'd4: m_fen = req_wdata[7:0];
                    3'd5: m_st  = m_st & ~req_wdata[7:0];
                    3'd6: m_dm  = req_wdata[23:0];
`ifdef GPIO_DEBOUNCE_EN
                    3'd7: m_db  = req_wdata[7:0];
`endif
                    default: ;
                endcase
            end
            m_st    = m_st | set;
            m_rsp   = acc;
            m_rdata = rd;
            s2 = s1;
            s1 = s0;
            s0 = pad_in;
        end
        #1;
        chk("ready", {31'h0, req_ready}, {31'h0, !m_rsp});
        chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_rsp});
        if (m_rsp && model_on) chk("rdata", rsp_rdata, m_rdata);
        chk("pad_out", {24'h0, pad_out}, {24'h0, m_out});
        chk("pad_oe_n", {24'h0, pad_oe_n}, {24'h0, ~m_oe});
        chk("pad_dm", {8'h0, pad_dm}, {8'h0, m_dm});
        chk("inp_dis", {24'h0, pad_inp_dis}, 32'h0);
        if (model_on) chk("irq", {31'h0, irq}, {31'h0, |m_st});
    endtask

    task automatic wr_req(input bit [2:0] a, input bit [31:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0; req_we = 1'b0;
        step();
    endtask

    task automatic rd_req(input string tag, input bit [2:0] a, input bit [31:0] exp);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        step();
        req_valid = 1'b0;
        chk(tag, rsp_rdata, exp);
        step();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        steps(3);
        rst = 1'b0;
        step();
        chk("rst_oe_n", {24'h0, pad_oe_n}, 32'hFF);
        chk("rst_dm", {8'h0, pad_dm}, 32'h249249);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);

        // Back-to-back requests: second is stalled for the response cycle.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd1; req_wdata = 32'hFF;
        step();
        chk("oe_n_ff", {24'h0, pad_oe_n}, 32'h0);
        chk("bb_ready", {31'h0, req_ready}, 32'h0);
        req_addr = 3'd0; req_wdata = 32'hA5;
        step();
        step();
        chk("out_a5", {24'h0, pad_out}, 32'hA5);
        req_valid = 1'b0; req_we = 1'b0;
        step();

        // Rise on pin 0: IN after 2 cycles, STATUS/irq after 3, then W1C.
        wr_req(3'd3, 32'h1);
        pad_in[0] = 1'b1;
        steps(2);
        chk("irq_early", {31'h0, irq}, 32'h0);
        step();
        chk("irq_rise", {31'h0, irq}, 32'h1);
        rd_req("in_pin0", 3'd2, 32'h1);
        rd_req("status_rd", 3'd5, 32'h1);
        wr_req(3'd5, 32'h1);
        chk("irq_clr", {31'h0, irq}, 32'h0);

        // Set STATUS again, then W1C lands on the same edge as a new rise.
        pad_in[0] = 1'b0; steps(4);
        pad_in[0] = 1'b1; steps(3);
        chk("irq_set2", {31'h0, irq}, 32'h1);
        pad_in[0] = 1'b0; steps(3);
        pad_in[0] = 1'b1; steps(2);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd5; req_wdata = 32'h1;
        step();
        req_valid = 1'b0; req_we = 1'b0;
        chk("w1c_vs_set", {31'h0, irq}, 32'h1);
        step();
        wr_req(3'd3, 32'h0);
        chk("irq_keep", {31'h0, irq}, 32'h1);
        wr_req(3'd5, 32'hFF);

        // Masking of unused bits and read-only IN.
        wr_req(3'd6, 32'h1B6);
        rd_req("dm_1b6", 3'd6, 32'h1B6);
        wr_req(3'd6, 32'hFFFF_FFFF);
        rd_req("dm_mask", 3'd6, 32'h00FF_FFFF);
        wr_req(3'd2, 32'hFF);
        rd_req("in_ro", 3'd2, 32'h1);
        wr_req(3'd0, 32'hFFFF_FF5A);
        rd_req("out_mask", 3'd0, 32'h5A);
        wr_req(3'd7, 32'h100);
        rd_req("db_mask", 3'd7, 32'h0);

        // Random traffic with sparse pad toggles and occasional reset.
        for (int c = 0; c < 600; c++) begin
            pad_in    = pad_in ^ 8'($urandom & $urandom & $urandom);
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 3'($urandom_range(0, 7));
            req_wdata = $urandom;
            if (req_addr == 3'd7) req_wdata = '0;
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        step();

`ifdef GPIO_DEBOUNCE_EN
        pad_in = '0;
        wr_req(3'd4, 32'h0);
        wr_req(3'd3, 32'h2);
        steps(5);
        wr_req(3'd5, 32'hFF);
        wr_req(3'd7, 32'h4);
        rd_req("db_rd", 3'd7, 32'h4);
        model_on = 1'b0;
        pad_in[1] = 1'b1; steps(3);
        pad_in[1] = 1'b0; steps(10);
        chk("glitch_irq", {31'h0, irq}, 32'h0);
        rd_req("glitch_in", 3'd2, 32'h0);
        pad_in[1] = 1'b1; steps(10);
        chk("pulse_irq", {31'h0, irq}, 32'h1);
        rd_req("pulse_in", 3'd2, 32'h2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
